// File: rtl/ramrom_pkg.sv
// ramrom_pkg: shared constants, region bounds and FSM states
// for the ramrom_mapper slice (register map, memory regions, latch bits).
package ramrom_pkg;

  localparam logic [15:0] ADDR_WRPROT   = 16'hBFFC;
  localparam logic [15:0] ADDR_JUMPER   = 16'hBFFD;
  localparam logic [15:0] ADDR_SWITCH   = 16'hBFFE;
  localparam logic [15:0] ADDR_ROMLATCH = 16'hBFFF;

  localparam logic [15:0] DSKRAM_LO = 16'h0A00;
  localparam logic [15:0] DSKRAM_HI = 16'h0AFF;
  localparam logic [15:0] LORAM_LO  = 16'h0B00;
  localparam logic [15:0] LORAM_HI  = 16'h6FFF;
  localparam logic [15:0] TOPRAM_LO = 16'h7000;
  localparam logic [15:0] TOPRAM_HI = 16'h7FFF;
  localparam logic [15:0] UPPER_LO  = 16'h8000;
  localparam logic [15:0] EXT_LO    = 16'hA000;
  localparam logic [15:0] EXT_HI    = 16'hAFFF;
  localparam logic [15:0] BUF_LO    = 16'hBC00;
  localparam logic [15:0] BUF_HI    = 16'hBFF0;
  localparam logic [15:0] HIROM_LO  = 16'hC000;
  localparam logic [15:0] HIROM_HI  = 16'hDFFF;
  localparam logic [15:0] DSKROM_LO = 16'hE000;
  localparam logic [15:0] DSKROM_HI = 16'hEFFF;
  localparam logic [15:0] OSROM_LO  = 16'hF000;

  localparam int SW_EXTRAM = 0;
  localparam int SW_DSKRAM = 1;
  localparam int SW_DSKROM = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACTIVE
  } state_e;

  function automatic logic in_range(
    input logic [15:0] a,
    input logic [15:0] lo,
    input logic [15:0] hi
  );
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/ramrom_mapper_if.sv
// ramrom_mapper_if: 6502-side bus bundle of the mapper.
// slave = mapper (Addr/PHI2/RW/DataIn/jumpers in), master = CPU/board side.
interface ramrom_mapper_if #(
  parameter int BANK_BITS = 4
);
  logic [15:0]        Addr;
  logic               PHI2;
  logic               RW;
  logic [7:0]         DataIn;
  logic [7:0]         DataOut;
  logic               DataOE;
  logic               SpeedSW;
  logic               DskROMSW;
  logic [BANK_BITS:0] RA;
  logic               NRDS;
  logic               NWDS;
  logic               NRAMCS;
  logic               NROMCS;
  logic               NBuffCtl;
  logic               RDY;

  modport slave (
    input  Addr, PHI2, RW, DataIn, SpeedSW, DskROMSW,
    output DataOut, DataOE, RA, NRDS, NWDS,
    output NRAMCS, NROMCS, NBuffCtl, RDY
  );

  modport master (
    output Addr, PHI2, RW, DataIn, SpeedSW, DskROMSW,
    input  DataOut, DataOE, RA, NRDS, NWDS,
    input  NRAMCS, NROMCS, NBuffCtl, RDY
  );
endinterface

// File: rtl/ramrom_phi2_sync.sv
// ramrom_phi2_sync: SYNC_STAGES-flop PHI2 synchroniser with one-clk
// rise/fall pulses. Ports: clk, rst (sync, high), phi2 in; phi2_rise/fall out.
module ramrom_phi2_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic phi2,
  output logic phi2_rise,
  output logic phi2_fall
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   last_q, last_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], phi2};
    last_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
    end
  end

  assign phi2_rise = sync_q[SYNC_STAGES-1] & ~last_q;
  assign phi2_fall = ~sync_q[SYNC_STAGES-1] & last_q;
endmodule

// File: rtl/ramrom_mapper.sv
// ramrom_mapper: clocked Atom RAM/ROM decoder with $BFFC-$BFFF registers
// and ROM wait states. Ports: Clk, Reset, bus (ramrom_mapper_if.slave).
// Optional macro RAMROM_WRPROT_EN: $BFFC write-protect register.
module ramrom_mapper
  import ramrom_pkg::*;
#(
  parameter int BANK_BITS   = 4,
  parameter int WAIT_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input logic             Clk,
  input logic             Reset,
  ramrom_mapper_if.slave  bus
);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [15:0]          cyc_addr_q, cyc_addr_d;
  logic                 cyc_rw_q, cyc_rw_d;
  logic [7:0]           data_in_q, data_in_d;
  logic [BANK_BITS-1:0] rom_latch_q, rom_latch_d;
  logic [3:0]           sw_q, sw_d;
  logic [1:0]           wp_q, wp_d;
  logic                 nrds_q, nrds_d, nwds_q, nwds_d;
  logic                 rdy_q, rdy_d, data_oe_q, data_oe_d;
  logic [7:0]           data_out_q, data_out_d;

  logic phi2_rise, phi2_fall;

  ramrom_phi2_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (Clk),
    .rst       (Reset),
    .phi2      (bus.PHI2),
    .phi2_rise (phi2_rise),
    .phi2_fall (phi2_fall)
  );

  logic [15:0]  a;
  logic         ext_ram_en, dsk_ram_en, dsk_rom_en;
  logic         ram_cs, rom_cs, in_ext;
  logic [BANK_BITS:0] ra;

  always_comb begin
    a          = bus.Addr;
    ext_ram_en = sw_q[SW_EXTRAM];
    dsk_ram_en = sw_q[SW_DSKRAM] ^ ~bus.DskROMSW;
    dsk_rom_en = sw_q[SW_DSKROM] ^ ~bus.DskROMSW;
    in_ext     = in_range(a, EXT_LO, EXT_HI);
    ram_cs = (a < DSKRAM_LO)
           | (in_range(a, DSKRAM_LO, DSKRAM_HI) & dsk_ram_en)
           | in_range(a, LORAM_LO, LORAM_HI)
           | (in_range(a, TOPRAM_LO, TOPRAM_HI) & ~ext_ram_en)
           | (in_ext & ext_ram_en & (rom_latch_q == '0));
    rom_cs = (in_ext & (~ext_ram_en | (rom_latch_q != '0)))
           | in_range(a, HIROM_LO, HIROM_HI)
           | (in_range(a, DSKROM_LO, DSKROM_HI) & dsk_rom_en)
           | (a >= OSROM_LO);
    ra = '0;
    if (ram_cs) begin
      ra = (a < UPPER_LO) ? (BANK_BITS+1)'(a[14:12])
                          : (BANK_BITS+1)'(3'b111);
    end else if (rom_cs) begin
      if (a < HIROM_LO) begin
        ra = {1'b0, rom_latch_q};
      end else begin
        ra = (BANK_BITS+1)'({~dsk_rom_en, a[13:12]});
        ra[BANK_BITS] = 1'b1;
      end
    end
  end

  assign bus.NRAMCS   = ~ram_cs;
  assign bus.NROMCS   = ~rom_cs;
  assign bus.RA       = ra;
  assign bus.NBuffCtl =
    ~((~dsk_ram_en & in_range(a, DSKRAM_LO, DSKRAM_HI))
    | (~dsk_rom_en & in_range(a, DSKROM_LO, DSKROM_HI))
    | in_range(a, BUF_LO, BUF_HI));

  // Register readback for the cycle about to be (or being) served.
  logic       rd_hit;
  logic [7:0] rd_val;
  logic       prot;

  always_comb begin
    rd_hit = 1'b1;
    rd_val = 8'h00;
    unique case (cyc_addr_d)
      ADDR_ROMLATCH: rd_val = 8'(rom_latch_q);
      ADDR_SWITCH:   rd_val = {4'b0, sw_q};
      ADDR_JUMPER:   rd_val = {4'b0, bus.SpeedSW, ~bus.DskROMSW, 2'b00};
`ifdef RAMROM_WRPROT_EN
      ADDR_WRPROT:   rd_val = {6'b0, wp_q};
`endif
      default:       rd_hit = 1'b0;
    endcase
`ifdef RAMROM_WRPROT_EN
    prot = (wp_q[0] & in_range(cyc_addr_d, EXT_LO, EXT_HI))
         | (wp_q[1] & in_range(cyc_addr_d, TOPRAM_LO, TOPRAM_HI));
`else
    prot = 1'b0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cyc_addr_d  = cyc_addr_q;
    cyc_rw_d    = cyc_rw_q;
    data_in_d   = data_in_q;
    rom_latch_d = rom_latch_q;
    sw_d        = sw_q;
    wp_d        = wp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (phi2_rise) begin
          cyc_addr_d = bus.Addr;
          cyc_rw_d   = bus.RW;
          if (bus.RW && rom_cs && !bus.SpeedSW && (WAIT_CYCLES > 0)) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = ST_ACTIVE;
          end
        end
      end
      ST_WAIT: begin
        // Only reads wait, so an early fall has nothing to commit.
        if (phi2_fall)          state_d = ST_IDLE;
        else if (cnt_q == '0)   state_d = ST_ACTIVE;
        else                    cnt_d   = cnt_q - CW'(1);
      end
      ST_ACTIVE: begin
        data_in_d = bus.DataIn;
        if (phi2_fall) begin
          state_d = ST_IDLE;
          if (!cyc_rw_q) begin
            unique case (cyc_addr_q)
              ADDR_ROMLATCH: rom_latch_d = data_in_q[BANK_BITS-1:0];
              ADDR_SWITCH:   sw_d        = data_in_q[3:0];
`ifdef RAMROM_WRPROT_EN
              ADDR_WRPROT:   wp_d        = data_in_q[1:0];
`endif
              default: ;
            endcase
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from next state so they line up with it.
    nrds_d     = ~((state_d == ST_ACTIVE) & cyc_rw_d);
    nwds_d     = ~((state_d == ST_ACTIVE) & ~cyc_rw_d & ~prot);
    rdy_d      = (state_d != ST_WAIT);
    data_oe_d  = (state_d == ST_ACTIVE) & cyc_rw_d & rd_hit;
    data_out_d = data_oe_d ? rd_val : 8'h00;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cyc_addr_q  <= '0;
      cyc_rw_q    <= 1'b1;
      data_in_q   <= '0;
      rom_latch_q <= '0;
      sw_q        <= '0;
      wp_q        <= '0;
      nrds_q      <= 1'b1;
      nwds_q      <= 1'b1;
      rdy_q       <= 1'b1;
      data_oe_q   <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_addr_q  <= cyc_addr_d;
      cyc_rw_q    <= cyc_rw_d;
      data_in_q   <= data_in_d;
      rom_latch_q <= rom_latch_d;
      sw_q        <= sw_d;
      wp_q        <= wp_d;
      nrds_q      <= nrds_d;
      nwds_q      <= nwds_d;
      rdy_q       <= rdy_d;
      data_oe_q   <= data_oe_d;
      data_out_q  <= data_out_d;
    end
  end

  // Bits not consumed by the narrower latches in every build.
  logic unused_bits;
  assign unused_bits = ^{data_in_q, wp_q};

  assign bus.NRDS    = nrds_q;
  assign bus.NWDS    = nwds_q;
  assign bus.RDY     = rdy_q;
  assign bus.DataOE  = data_oe_q;
  assign bus.DataOut = data_out_q;
endmodule
